// File: rtl/cpld_bus_cycle_decoder.sv
`default_nettype none
// cpld_bus_cycle_decoder: classifies Z80 machine cycles, counts wait states,
// flags bus errors/timeouts and captures bank-select I/O writes into ramcfg.
module cpld_bus_cycle_decoder #(
  parameter int         WAIT_W  = 4,
  parameter int         TIMEOUT = 64,
  parameter logic [5:0] CFG_RST = 6'h00
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              mreq_b,
  input  logic              iorq_b,
  input  logic              rd_b,
  input  logic              wr_b,
  input  logic              rfsh_b,
  input  logic              m1_b,
  input  logic              ready,
  input  logic              adr15,
  input  logic              adr14,
  input  logic [7:0]        data,
  output logic [2:0]        cyc_type,
  output logic              cyc_active,
  output logic              cyc_start,
  output logic              cyc_end,
  output logic [1:0]        cyc_adr,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic [5:0]        ramcfg,
  output logic              cfg_stb,
  output logic              bus_err
);

  typedef enum logic [2:0] {IDLE, MEM, RFSH, IO, DRAIN} state_t;

  localparam logic [2:0]        T_NONE  = 3'd0;
  localparam logic [2:0]        T_MRD   = 3'd1;
  localparam logic [2:0]        T_MWR   = 3'd2;
  localparam logic [2:0]        T_RFSH  = 3'd3;
  localparam logic [2:0]        T_IORD  = 3'd4;
  localparam logic [2:0]        T_IOWR  = 3'd5;
  localparam logic [2:0]        T_INTA  = 3'd6;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic       mreq_q, iorq_q;
  logic       mreq_arm, iorq_arm;
  logic       cfg_done;
  logic [7:0] tcnt;
  logic       mreq_fall, iorq_fall, exit_now, cfg_hit;

  // A strobe only counts as a falling edge once the line has been seen high,
  // so a level held low straight out of reset never opens a cycle.
  assign mreq_fall = !mreq_b && mreq_q && mreq_arm;
  assign iorq_fall = !iorq_b && iorq_q && iorq_arm;
  assign exit_now  = (state == IO) ? iorq_b : mreq_b;
  assign cfg_hit   = (state == IO) && (cyc_type == T_IOWR) && !cfg_done &&
                     !wr_b && !adr15 && (data[7:6] == 2'b11);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      mreq_arm   <= 1'b0;
      iorq_arm   <= 1'b0;
      cfg_done   <= 1'b0;
      tcnt       <= 8'd0;
      cyc_type   <= T_NONE;
      cyc_active <= 1'b0;
      cyc_start  <= 1'b0;
      cyc_end    <= 1'b0;
      cyc_adr    <= 2'b00;
      wait_cnt   <= '0;
      ramcfg     <= CFG_RST;
      cfg_stb    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      mreq_q    <= mreq_b;
      iorq_q    <= iorq_b;
      cyc_start <= 1'b0;
      cyc_end   <= 1'b0;
      cfg_stb   <= 1'b0;
      if (mreq_b) mreq_arm <= 1'b1;
      if (iorq_b) iorq_arm <= 1'b1;

      case (state)
        IDLE: begin
          if (mreq_fall || iorq_fall) begin
            if (!mreq_b && !iorq_b) begin
              bus_err <= 1'b1;
            end else begin
              cyc_start  <= 1'b1;
              cyc_active <= 1'b1;
              cyc_adr    <= {adr15, adr14};
              wait_cnt   <= '0;
              tcnt       <= 8'd0;
              cfg_done   <= 1'b0;
              if (mreq_fall) begin
                if (!rfsh_b) begin
                  state    <= RFSH;
                  cyc_type <= T_RFSH;
                end else begin
                  state    <= MEM;
                  cyc_type <= rd_b ? T_MWR : T_MRD;
                end
              end else begin
                state    <= IO;
                cyc_type <= !m1_b ? T_INTA : (!rd_b ? T_IORD : T_IOWR);
              end
            end
          end
        end

        MEM, RFSH, IO: begin
          if (state != RFSH && !ready && wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
          if (cfg_hit) begin
            ramcfg   <= data[5:0];
            cfg_stb  <= 1'b1;
            cfg_done <= 1'b1;
          end
          if (exit_now) begin
            state      <= IDLE;
            cyc_active <= 1'b0;
            cyc_end    <= 1'b1;
          end else if (tcnt == TO_LAST) begin
            state   <= DRAIN;
            bus_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        DRAIN: begin
          if (mreq_b && iorq_b) begin
            state      <= IDLE;
            cyc_active <= 1'b0;
            cyc_end    <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpld_bus_cycle_decoder.sv
`default_nettype none
// Directed bench for cpld_bus_cycle_decoder with hand-computed expectations.
module tb_cpld_bus_cycle_decoder;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15, adr14;
  logic [7:0] data;
  logic [2:0] cyc_type;
  logic       cyc_active, cyc_start, cyc_end, cfg_stb, bus_err;
  logic [1:0] cyc_adr;
  logic [3:0] wait_cnt;
  logic [5:0] ramcfg;

  int checks   = 0;
  int failures = 0;

  cpld_bus_cycle_decoder #(.WAIT_W(4), .TIMEOUT(64), .CFG_RST(6'h00)) dut (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
    .rd_b(rd_b), .wr_b(wr_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .ready(ready),
    .adr15(adr15), .adr14(adr14), .data(data), .cyc_type(cyc_type),
    .cyc_active(cyc_active), .cyc_start(cyc_start), .cyc_end(cyc_end),
    .cyc_adr(cyc_adr), .wait_cnt(wait_cnt), .ramcfg(ramcfg),
    .cfg_stb(cfg_stb), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    rfsh_b = 1'b1; m1_b = 1'b1; ready = 1'b1; adr15 = 1'b0; adr14 = 1'b0;
    data = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_type"},   32'(cyc_type), 0);
    chk({tag, "_active"}, 32'(cyc_active), 0);
    chk({tag, "_start"},  32'(cyc_start), 0);
    chk({tag, "_end"},    32'(cyc_end), 0);
    chk({tag, "_adr"},    32'(cyc_adr), 0);
    chk({tag, "_wait"},   32'(wait_cnt), 0);
    chk({tag, "_ramcfg"}, 32'(ramcfg), 0);
    chk({tag, "_stb"},    32'(cfg_stb), 0);
    chk({tag, "_err"},    32'(bus_err), 0);
  endtask

  // IO write cycle: three clks with IORQ low, then release.
  task automatic io_write(input logic a15, input logic [7:0] d,
                          input int exp_stb, input logic [5:0] exp_cfg, input string tag);
    int stb_cnt = 0;
    iorq_b = 1'b0; wr_b = 1'b0; adr15 = a15; data = d;
    tick();
    chk({tag, "_start"}, 32'(cyc_start), 1);
    chk({tag, "_type"},  32'(cyc_type), 5);
    stb_cnt += int'(cfg_stb);
    tick(); stb_cnt += int'(cfg_stb);
    tick(); stb_cnt += int'(cfg_stb);
    iorq_b = 1'b1; wr_b = 1'b1;
    tick(); stb_cnt += int'(cfg_stb);
    chk({tag, "_end"},    32'(cyc_end), 1);
    chk({tag, "_stbcnt"}, 32'(stb_cnt), 32'(exp_stb));
    chk({tag, "_ramcfg"}, 32'(ramcfg), 32'(exp_cfg));
    adr15 = 1'b0; data = 8'h00;
    tick();
  endtask

  initial begin
    idle_bus();
    reset_b = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset_b = 1'b1;
    tick();

    // Bank-select write then reset mid-MEM restores CFG_RST at once
    io_write(1'b0, 8'hC2, 1, 6'h02, "io_c2");
    mreq_b = 1'b0; rd_b = 1'b0; adr15 = 1'b1;
    tick(); tick(); tick();
    chk("mid_mem_active", 32'(cyc_active), 1);
    #2 reset_b = 1'b0;
    #1 chk_reset_vals("async_rst");
    // MREQ still low out of reset: no cycle may start
    tick();
    reset_b = 1'b1;
    tick(); tick();
    chk("held_low_nostart", 32'(cyc_active), 0);
    chk("held_low_noerr",   32'(bus_err), 0);
    idle_bus();
    tick();

    // Mem read A15:14=01, two wait clks
    mreq_b = 1'b0; rd_b = 1'b0; adr14 = 1'b1;
    tick();
    chk("mrd_start", 32'(cyc_start), 1);
    chk("mrd_type",  32'(cyc_type), 1);
    chk("mrd_adr",   32'(cyc_adr), 1);
    chk("mrd_wait0", 32'(wait_cnt), 0);
    ready = 1'b0;
    tick(); tick();
    ready = 1'b1;
    tick();
    chk("mrd_start_once", 32'(cyc_start), 0);
    chk("mrd_wait_mid", 32'(wait_cnt), 2);
    mreq_b = 1'b1; rd_b = 1'b1;
    tick();
    chk("mrd_end",    32'(cyc_end), 1);
    chk("mrd_active", 32'(cyc_active), 0);
    chk("mrd_wait",   32'(wait_cnt), 2);
    chk("mrd_type_hold", 32'(cyc_type), 1);
    tick();
    chk("mrd_end_pulse", 32'(cyc_end), 0);
    chk("mrd_wait_hold", 32'(wait_cnt), 2);

    // Bank-select filtering
    io_write(1'b0, 8'hC5, 1, 6'h05, "io_c5");
    io_write(1'b0, 8'h82, 0, 6'h05, "io_82");
    io_write(1'b1, 8'hC3, 0, 6'h05, "io_a15");

    // Opcode fetch followed directly by refresh
    mreq_b = 1'b0; rd_b = 1'b0; m1_b = 1'b0;
    tick();
    chk("m1_type", 32'(cyc_type), 1);
    tick();
    mreq_b = 1'b1; rd_b = 1'b1; m1_b = 1'b1;
    tick();
    chk("m1_end", 32'(cyc_end), 1);
    mreq_b = 1'b0; rfsh_b = 1'b0;
    tick();
    chk("rf_start", 32'(cyc_start), 1);
    chk("rf_no_end", 32'(cyc_end), 0);
    chk("rf_type", 32'(cyc_type), 3);
    tick();
    mreq_b = 1'b1; rfsh_b = 1'b1;
    tick();
    chk("rf_end", 32'(cyc_end), 1);
    chk("rf_noerr", 32'(bus_err), 0);
    tick();

    // Memory write stays type 2 after WR asserts
    mreq_b = 1'b0;
    tick();
    chk("mwr_type", 32'(cyc_type), 2);
    wr_b = 1'b0;
    tick();
    chk("mwr_type_hold", 32'(cyc_type), 2);
    idle_bus();
    tick(); tick();

    // IO read and interrupt acknowledge
    iorq_b = 1'b0; rd_b = 1'b0;
    tick();
    chk("iord_type", 32'(cyc_type), 4);
    idle_bus();
    tick(); tick();
    iorq_b = 1'b0; m1_b = 1'b0;
    tick();
    chk("inta_type", 32'(cyc_type), 6);
    idle_bus();
    tick(); tick();
    chk("ramcfg_kept", 32'(ramcfg), 5);

    // Wait count saturation
    mreq_b = 1'b0; rd_b = 1'b0; ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("wait_sat15", 32'(wait_cnt), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("wait_nowrap", 32'(wait_cnt), 15);
    idle_bus();
    tick(); tick();

    // Simultaneous MREQ/IORQ fall
    mreq_b = 1'b0; iorq_b = 1'b0;
    tick();
    chk("both_err",     32'(bus_err), 1);
    chk("both_nostart", 32'(cyc_start), 0);
    chk("both_idle",    32'(cyc_active), 0);
    idle_bus();
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    tick();
    chk("err_cleared", 32'(bus_err), 0);

    // Timeout: 64 clks in MEM, then DRAIN until MREQ rises
    mreq_b = 1'b0; rd_b = 1'b0;
    tick();
    chk("to_start", 32'(cyc_start), 1);
    for (int i = 0; i < 63; i++) tick();
    chk("to_before", 32'(bus_err), 0);
    tick();
    chk("to_err",    32'(bus_err), 1);
    chk("to_active", 32'(cyc_active), 1);
    chk("to_noend",  32'(cyc_end), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("drain_noend", 32'(cyc_end), 0);
    mreq_b = 1'b1; rd_b = 1'b1;
    tick();
    chk("drain_end",    32'(cyc_end), 1);
    chk("drain_idle",   32'(cyc_active), 0);
    tick();
    chk("err_sticky",   32'(bus_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
